// File: rtl/alu_ctrl.sv
// Request/response sequencer for an external combinational ALU: latches operands,
// captures the result one cycle later, and keeps an accumulator, sticky overflow and op counter.
module alu_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic [2:0]   req_op,
  input  logic         req_acc,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_y,
  input  logic         alu_zero,
  input  logic         alu_negative,
  input  logic         alu_carry,
  input  logic         alu_overflow,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_y,
  output logic [3:0]   rsp_flags,
  output logic [W-1:0] acc,
  input  logic         clr_sticky,
  output logic         sticky_ovf,
  output logic [15:0]  op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e        state_q;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic [W-1:0]  alu_a_q;
  logic [W-1:0]  alu_b_q;
  logic [2:0]    alu_op_q;
  logic [W-1:0]  rsp_y_q;
  logic [3:0]    rsp_flags_q;
  logic [W-1:0]  acc_q;
  logic          sticky_q;
  logic          sticky_d;
  logic [15:0]   op_count_q;
  logic [15:0]   op_count_d;

  // Sticky overflow: a captured overflow beats a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if ((state_q == ST_EXEC) && alu_overflow) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Completed-operation counter, saturating.
  always_comb begin
    op_count_d = op_count_q;
    if ((state_q == ST_EXEC) && (op_count_q != 16'hFFFF)) begin
      op_count_d = op_count_q + 16'd1;
    end else begin
      op_count_d = op_count_q;
    end
  end

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= 3'd0;
      rsp_y_q     <= '0;
      rsp_flags_q <= 4'd0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      op_count_q  <= 16'd0;
    end else begin
      sticky_q   <= sticky_d;
      op_count_q <= op_count_d;
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            alu_a_q     <= req_acc ? acc_q : req_a;
            alu_b_q     <= req_b;
            alu_op_q    <= req_op;
            req_ready_q <= 1'b0;
            state_q     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_y_q     <= alu_y;
          rsp_flags_q <= {alu_zero, alu_negative, alu_carry, alu_overflow};
          acc_q       <= alu_y;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_y      = rsp_y_q;
  assign rsp_flags  = rsp_flags_q;
  assign acc        = acc_q;
  assign sticky_ovf = sticky_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl: a behavioural ALU closes the loop, directed requests push
// hand-computed results, and a negedge monitor pops and compares on every response handshake.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_a = 8'h00;
  logic [7:0]  req_b = 8'h00;
  logic [2:0]  req_op = 3'd0;
  logic        req_acc = 1'b0;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic [7:0]  alu_y;
  logic        alu_zero;
  logic        alu_negative;
  logic        alu_carry;
  logic        alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_y;
  logic [3:0]  rsp_flags;
  logic [7:0]  acc;
  logic        clr_sticky = 1'b0;
  logic        sticky_ovf;
  logic [15:0] op_count;

  typedef struct packed {
    logic [7:0] y;
    logic [3:0] f;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [8:0] sum_s;
  int total = 0;
  int bad = 0;

  alu_ctrl #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_acc(req_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_flags(rsp_flags), .acc(acc),
    .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Reference ALU; carry on SUB means "no borrow".
  always_comb begin
    sum_s        = 9'd0;
    alu_y        = 8'h00;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      3'd0: alu_y = alu_a & alu_b;
      3'd1: alu_y = alu_a | alu_b;
      3'd2: alu_y = alu_a ^ alu_b;
      3'd3: begin
        sum_s        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_y        = sum_s[7:0];
        alu_carry    = sum_s[8];
        alu_overflow = (alu_a[7] == alu_b[7]) && (sum_s[7] != alu_a[7]);
      end
      3'd4: begin
        sum_s        = {1'b0, alu_a} - {1'b0, alu_b};
        alu_y        = sum_s[7:0];
        alu_carry    = ~sum_s[8];
        alu_overflow = (alu_a[7] != alu_b[7]) && (sum_s[7] != alu_a[7]);
      end
      3'd5: alu_y = alu_a << alu_b[2:0];
      3'd6: alu_y = alu_a >> alu_b[2:0];
      default: alu_y = alu_a;
    endcase
    alu_zero     = (alu_y == 8'h00);
    alu_negative = alu_y[7];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: one compare per handshake.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got y=%0h flags=%0h expected no response", rsp_y, rsp_flags);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_y", 32'(rsp_y), 32'(mon_e.y));
        chk("rsp_flags", 32'(rsp_flags), 32'(mon_e.f));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits for req_ready, presents one request and returns just after the acceptance edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic sel, input logic [7:0] ey, input logic [3:0] ef,
                      input bit push);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got req_ready=%b expected 1", req_ready);
    end
    if (push) exp_q.push_back({ey, ef});
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_acc   = sel;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_acc   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cycles(2);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_alu_a", 32'(alu_a), 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'h0);
    chk("rst_rsp_y", 32'(rsp_y), 32'h0);
    chk("rst_acc", 32'(acc), 32'h0);
    chk("rst_op_count", 32'(op_count), 32'h0);
    chk("rst_sticky", 32'(sticky_ovf), 32'h0);
    rst_n = 1'b1;
    chk("rst_req_ready", 32'(req_ready), 32'h1);

    // ADD overflow, latency and capture side effects
    send(8'h7F, 8'h01, 3'd3, 1'b0, 8'h80, 4'b0101, 1'b1);
    chk("lat_not_yet", 32'(rsp_valid), 32'h0);
    chk("lat_alu_a", 32'(alu_a), 32'h7F);
    chk("lat_alu_op", 32'(alu_op), 32'h3);
    chk("lat_req_ready", 32'(req_ready), 32'h0);
    cycles(1);
    chk("lat_valid", 32'(rsp_valid), 32'h1);
    chk("add_sticky", 32'(sticky_ovf), 32'h1);
    chk("add_count", 32'(op_count), 32'h1);
    chk("add_acc", 32'(acc), 32'h80);
    cycles(1);
    chk("hs_valid_low", 32'(rsp_valid), 32'h0);
    chk("hs_ready_high", 32'(req_ready), 32'h1);

    // SUB to zero, then accumulator chaining
    send(8'h05, 8'h05, 3'd4, 1'b0, 8'h00, 4'b1010, 1'b1);
    cycles(2);
    chk("sub_acc", 32'(acc), 32'h0);
    send(8'hEE, 8'h03, 3'd3, 1'b1, 8'h03, 4'b0000, 1'b1);
    chk("acc_sel_alu_a", 32'(alu_a), 32'h0);
    cycles(2);
    chk("acc_chain", 32'(acc), 32'h03);
    clr_sticky = 1'b1;
    cycles(1);
    clr_sticky = 1'b0;
    chk("clr_sticky", 32'(sticky_ovf), 32'h0);

    // Remaining op codes
    send(8'hF0, 8'h3C, 3'd0, 1'b0, 8'h30, 4'b0000, 1'b1); cycles(2);
    send(8'hF0, 8'h0F, 3'd1, 1'b0, 8'hFF, 4'b0100, 1'b1); cycles(2);
    send(8'hAA, 8'hAA, 3'd2, 1'b0, 8'h00, 4'b1000, 1'b1); cycles(2);
    send(8'h81, 8'h01, 3'd5, 1'b0, 8'h02, 4'b0000, 1'b1); cycles(2);
    send(8'h80, 8'h03, 3'd6, 1'b0, 8'h10, 4'b0000, 1'b1); cycles(2);
    send(8'h9C, 8'h11, 3'd7, 1'b0, 8'h9C, 4'b0100, 1'b1); cycles(2);
    send(8'h00, 8'h64, 3'd3, 1'b1, 8'h00, 4'b1010, 1'b1); cycles(2);
    chk("wrap_acc", 32'(acc), 32'h0);
    chk("no_ovf_sticky", 32'(sticky_ovf), 32'h0);
    chk("count_10", 32'(op_count), 32'd10);

    // Response back-pressure with a competing request held off
    rsp_ready = 1'b0;
    send(8'hFF, 8'h55, 3'd0, 1'b0, 8'h55, 4'b0000, 1'b1);
    cycles(1);
    req_a     = 8'h11;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(rsp_valid), 32'h1);
      chk("stall_y", 32'(rsp_y), 32'h55);
      chk("stall_req_ready", 32'(req_ready), 32'h0);
      chk("stall_alu_a", 32'(alu_a), 32'hFF);
      cycles(1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    cycles(1);
    chk("release_valid", 32'(rsp_valid), 32'h0);
    chk("release_ready", 32'(req_ready), 32'h1);

    // Set wins over a simultaneous clear
    send(8'h80, 8'h80, 3'd3, 1'b0, 8'h00, 4'b1011, 1'b1);
    clr_sticky = 1'b1;
    cycles(1);
    chk("set_wins", 32'(sticky_ovf), 32'h1);
    cycles(1);
    clr_sticky = 1'b0;
    chk("clr_alone", 32'(sticky_ovf), 32'h0);

    // Reset during EXEC drops the request
    send(8'h01, 8'h01, 3'd3, 1'b0, 8'h00, 4'b0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_alu_a", 32'(alu_a), 32'h0);
    chk("mid_rst_alu_b", 32'(alu_b), 32'h0);
    chk("mid_rst_flags", 32'(rsp_flags), 32'h0);
    chk("mid_rst_acc", 32'(acc), 32'h0);
    chk("mid_rst_count", 32'(op_count), 32'h0);
    cycles(2);
    rst_n = 1'b1;
    chk("post_rst_valid", 32'(rsp_valid), 32'h0);
    send(8'h02, 8'h03, 3'd3, 1'b0, 8'h05, 4'b0000, 1'b1);
    chk("first_edge_accept", 32'(req_ready), 32'h0);
    cycles(2);
    chk("post_rst_count", 32'(op_count), 32'h1);

    // Counter saturation from a preloaded value
    force dut.op_count_q = 16'hFFFD;
    cycles(1);
    release dut.op_count_q;
    chk("preload", 32'(op_count), 32'hFFFD);
    send(8'h0F, 8'h0F, 3'd0, 1'b0, 8'h0F, 4'b0000, 1'b1); cycles(2);
    chk("count_fffe", 32'(op_count), 32'hFFFE);
    send(8'h0F, 8'h0F, 3'd0, 1'b0, 8'h0F, 4'b0000, 1'b1); cycles(2);
    chk("count_ffff", 32'(op_count), 32'hFFFF);
    send(8'h0F, 8'h0F, 3'd0, 1'b0, 8'h0F, 4'b0000, 1'b1); cycles(2);
    chk("count_sat", 32'(op_count), 32'hFFFF);

    cycles(3);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
